countdown_timer: RTL and testbench

// - Down-counting MM:SS timer; the count-down counterpart of the lab's up-counting minute/second stopwatch counters.
// - Loads a preset, decrements once per external 1 Hz tick while running, flags expiry, and can be paused, resumed or cleared.
// - Sits between the 1 Hz tick generator and the 7-segment display/BCD conversion path; control pulses come from debounced one-pulse buttons.
//

---
 rtl/countdown_timer_if.sv | 24 ++
 rtl/countdown_timer.sv | 89 ++++++++
 tb/tb_countdown_timer.sv | 107 ++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the button/tick logic and the MM:SS countdown timer.
interface countdown_timer_if;
    logic       tick;
    logic       load;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic       start_stop;
    logic       clear;
    logic [5:0] minute;
    logic [5:0] second;
    logic       running;
    logic       expired;
    logic       done;

    modport master (
        output tick, load, load_min, load_sec, start_stop, clear,
        input  minute, second, running, expired, done
    );

    modport slave (
        input  tick, load, load_min, load_sec, start_stop, clear,
        output minute, second, running, expired, done
    );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS down-counter: loads a clamped preset, decrements on each 1 Hz tick while
// running, flags expiry, and supports pause/resume/clear.
module countdown_timer #(
    parameter int MAX_VAL = 59
) (
    input  logic              clk,
    input  logic              rst_n,
    countdown_timer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [5:0] MAX = 6'(MAX_VAL);

    state_t     r_state, w_nstate;
    logic [5:0] r_pre_min, r_pre_sec;
    logic [5:0] r_min, r_sec;
    logic       r_done;
    logic [5:0] w_ld_min, w_ld_sec;
    logic       w_nonzero, w_last, w_load_ok, w_dec;

    always_comb begin
        w_ld_min  = (bus.load_min > MAX) ? MAX : bus.load_min;
        w_ld_sec  = (bus.load_sec > MAX) ? MAX : bus.load_sec;
        w_nonzero = (r_min != 6'd0) || (r_sec != 6'd0);
        w_last    = (r_min == 6'd0) && (r_sec == 6'd1);
        w_load_ok = bus.load && (r_state != RUN);
        // A start_stop in the same RUN cycle pauses and swallows the tick.
        w_dec     = bus.tick && (r_state == RUN) && !bus.start_stop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        if (bus.clear)
            w_nstate = IDLE;
        else if (w_load_ok)
            w_nstate = IDLE;
        else if (bus.start_stop) begin
            case (r_state)
                IDLE:    if (w_nonzero) w_nstate = RUN;
                RUN:     w_nstate = PAUSE;
                PAUSE:   w_nstate = RUN;
                default: w_nstate = r_state;
            endcase
        end
        else if (w_dec && w_last)
            w_nstate = DONE;
    end

    always_comb begin
        bus.running = (r_state == RUN);
        bus.expired = (r_state == DONE);
        bus.done    = r_done;
        bus.minute  = r_min;
        bus.second  = r_sec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_min <= 6'd0;
            r_pre_sec <= 6'd0;
            r_min     <= 6'd0;
            r_sec     <= 6'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (w_nstate == DONE) && (r_state != DONE);
            if (bus.clear) begin
                r_min <= r_pre_min;
                r_sec <= r_pre_sec;
            end else if (w_load_ok) begin
                r_pre_min <= w_ld_min;
                r_pre_sec <= w_ld_sec;
                r_min     <= w_ld_min;
                r_sec     <= w_ld_sec;
            end else if (w_dec) begin
                if (r_sec != 6'd0)
                    r_sec <= r_sec - 6'd1;
                else if (r_min != 6'd0) begin
                    r_min <= r_min - 6'd1;
                    r_sec <= MAX;
                end
            end
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// Directed checks of the countdown timer: reset, borrow, expiry, pause priority,
// clamping, load-in-RUN, and clear priority.
module tb_countdown_timer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    countdown_timer_if bus();

    countdown_timer #(.MAX_VAL(59)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input logic t, input logic l, input logic [5:0] lm,
                        input logic [5:0] ls, input logic s, input logic c);
        @(negedge clk);
        bus.tick = t; bus.load = l; bus.load_min = lm; bus.load_sec = ls;
        bus.start_stop = s; bus.clear = c;
        @(posedge clk);
        #1;
        bus.tick = 1'b0; bus.load = 1'b0; bus.start_stop = 1'b0; bus.clear = 1'b0;
    endtask

    task automatic tk();                              step(1, 0, 0, 0, 0, 0); endtask
    task automatic ss();                              step(0, 0, 0, 0, 1, 0); endtask
    task automatic ld(input logic [5:0] m, input logic [5:0] s); step(0, 1, m, s, 0, 0); endtask
    task automatic idle();                            step(0, 0, 0, 0, 0, 0); endtask

    task automatic chk(input string tag, input logic [5:0] m, input logic [5:0] s,
                       input logic r, input logic e, input logic d);
        n_vec++;
        assert (bus.minute === m && bus.second === s && bus.running === r &&
                bus.expired === e && bus.done === d)
        else begin
            n_err++;
            $error("FAIL %s: got %0d:%0d run=%b exp=%b done=%b, want %0d:%0d run=%b exp=%b done=%b",
                   tag, bus.minute, bus.second, bus.running, bus.expired, bus.done,
                   m, s, r, e, d);
        end
    endtask

    initial begin
        bus.tick = 0; bus.load = 0; bus.load_min = 0; bus.load_sec = 0;
        bus.start_stop = 0; bus.clear = 0;
        #12;
        chk("reset", 0, 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;

        // Borrow from minutes
        ld(1, 2);  chk("load_0102", 1, 2, 0, 0, 0);
        ss();      chk("start", 1, 2, 1, 0, 0);
        tk();      chk("t1_0101", 1, 1, 1, 0, 0);
        tk();      chk("t2_0100", 1, 0, 1, 0, 0);
        tk();      chk("t3_0059", 0, 59, 1, 0, 0);

        // Async reset mid-run
        @(negedge clk); rst_n = 1'b0; #1;
        chk("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        ss();      chk("start_at_zero", 0, 0, 0, 0, 0);

        // Expiry
        ld(0, 2);  chk("load_0002", 0, 2, 0, 0, 0);
        ss();      chk("start2", 0, 2, 1, 0, 0);
        tk();      chk("t_0001", 0, 1, 1, 0, 0);
        tk();      chk("expire", 0, 0, 0, 1, 1);
        idle();    chk("done_pulse_end", 0, 0, 0, 1, 0);
        tk();      chk("tick_in_done", 0, 0, 0, 1, 0);
        ss();      chk("ss_in_done", 0, 0, 0, 1, 0);

        // Pause beats tick
        ld(0, 10); chk("load_from_done", 0, 10, 0, 0, 0);
        ss();      chk("start3", 0, 10, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0); chk("pause_drops_tick", 0, 10, 0, 0, 0);
        for (int i = 0; i < 5; i++) tk();
        chk("paused_ticks", 0, 10, 0, 0, 0);
        ss();      chk("resume", 0, 10, 1, 0, 0);
        tk();      chk("t_0009", 0, 9, 1, 0, 0);

        // Load ignored while running; clamp when accepted
        ld(63, 60); chk("load_in_run", 0, 9, 1, 0, 0);
        tk();      chk("t_0008", 0, 8, 1, 0, 0);
        ss();      chk("pause2", 0, 8, 0, 0, 0);
        ld(63, 60); chk("clamp", 59, 59, 0, 0, 0);
        ss();      chk("start_5959", 59, 59, 1, 0, 0);
        ss();      chk("pause_5959", 59, 59, 0, 0, 0);

        // Clear beats load; clear in DONE
        ld(0, 5);  chk("load_0005", 0, 5, 0, 0, 0);
        ss();      chk("start4", 0, 5, 1, 0, 0);
        tk(); tk(); chk("t_0003", 0, 3, 1, 0, 0);
        step(0, 1, 0, 7, 0, 1); chk("clear_wins", 0, 5, 0, 0, 0);
        ss();
        for (int i = 0; i < 4; i++) tk();
        chk("t_0001b", 0, 1, 1, 0, 0);
        tk();      chk("expire2", 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1); chk("clear_done", 0, 5, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
